// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encodings, bus widths and decode helpers for the local-bus blocks.
// Arbiter FSM state type lives here so other blocks can observe it.
package ddr3_pkg;

   localparam int unsigned ADDR_W  = 26;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned MASK_W  = 8;
   localparam int unsigned BURST_W = 5;
   localparam int unsigned CMD_W   = 4;

   localparam logic [CMD_W-1:0] CMD_READ   = 4'b0001;
   localparam logic [CMD_W-1:0] CMD_READA  = 4'b0011;
   localparam logic [CMD_W-1:0] CMD_WRITE  = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_WRITEA = 4'b0100;

   typedef enum logic [1:0] {StIdle, StIssue, StWdata, StRdata} arb_state_e;

   function automatic logic is_read(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_READA);
   endfunction

   function automatic logic is_write(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_WRITEA);
   endfunction

   // Burst count field of zero encodes the maximum burst of 32 units.
   function automatic logic [5:0] burst_units(input logic [BURST_W-1:0] burst);
      return (burst == '0) ? 6'd32 : {1'b0, burst};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = req;
      end
   end

endmodule

// File: rtl/ddr3_cmd_arbiter.sv
// Arbitrates two local-bus requesters onto a single DDR3 controller command/data port,
// one transaction in flight, with a read-beat watchdog.
module ddr3_cmd_arbiter
   import ddr3_pkg::*;
#(
   parameter int unsigned BEATS_PER_BURST = 2,
   parameter int unsigned RD_TIMEOUT      = 1023
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_done,
   input  logic               r0_req,
   input  logic [CMD_W-1:0]   r0_cmd,
   input  logic [ADDR_W-1:0]  r0_addr,
   input  logic [BURST_W-1:0] r0_burst,
   output logic               r0_ack,
   input  logic [DATA_W-1:0]  r0_wdata,
   input  logic [MASK_W-1:0]  r0_wmask,
   output logic               r0_wrdy,
   output logic               r0_rvalid,
   input  logic               r1_req,
   input  logic [CMD_W-1:0]   r1_cmd,
   input  logic [ADDR_W-1:0]  r1_addr,
   input  logic [BURST_W-1:0] r1_burst,
   output logic               r1_ack,
   input  logic [DATA_W-1:0]  r1_wdata,
   input  logic [MASK_W-1:0]  r1_wmask,
   output logic               r1_wrdy,
   output logic               r1_rvalid,
   output logic [DATA_W-1:0]  rdata,
   input  logic               mc_cmd_rdy,
   input  logic               mc_datain_rdy,
   input  logic               mc_read_data_valid,
   input  logic [DATA_W-1:0]  mc_read_data,
   output logic               mc_cmd_valid,
   output logic [CMD_W-1:0]   mc_cmd,
   output logic [ADDR_W-1:0]  mc_addr,
   output logic [BURST_W-1:0] mc_burst_cnt,
   output logic [DATA_W-1:0]  mc_write_data,
   output logic [MASK_W-1:0]  mc_data_mask,
   output logic               busy,
   output logic               timeout_err
);

   localparam int unsigned CntW = $clog2(32 * BEATS_PER_BURST + 1);
   localparam int unsigned TmrW = $clog2(RD_TIMEOUT + 1);

   arb_state_e         state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_q, last_d;
   logic [CMD_W-1:0]   cmd_q, cmd_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [TmrW-1:0]    tmr_q, tmr_d;
   logic               terr_q, terr_d;
   logic [1:0]         grant;

   rr_arb2 u_rr_arb2 (
      .req   ({r1_req, r0_req}),
      .last  (last_q),
      .grant (grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cmd_q   <= '0;
         addr_q  <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         terr_q  <= terr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      terr_d  = terr_q;
      unique case (state_q)
         StIdle: begin
            if (init_done && (grant != 2'b00)) begin
               owner_d = grant[1];
               last_d  = grant[1];
               cmd_d   = grant[1] ? r1_cmd   : r0_cmd;
               addr_d  = grant[1] ? r1_addr  : r0_addr;
               burst_d = grant[1] ? r1_burst : r0_burst;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (mc_cmd_rdy) begin
               cnt_d = CntW'(32'(burst_units(burst_q)) * BEATS_PER_BURST);
               tmr_d = '0;
               if (is_read(cmd_q)) begin
                  state_d = StRdata;
               end else if (is_write(cmd_q)) begin
                  state_d = StWdata;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StWdata: begin
            if (mc_datain_rdy) begin
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q == CntW'(1)) state_d = StIdle;
            end
         end
         StRdata: begin
            if (mc_read_data_valid) begin
               cnt_d = cnt_q - CntW'(1);
               tmr_d = '0;
               if (cnt_q == CntW'(1)) state_d = StIdle;
            end else if (tmr_q == TmrW'(RD_TIMEOUT - 1)) begin
               // RD_TIMEOUT consecutive idle cycles: give up on the rest of the burst.
               terr_d  = 1'b1;
               state_d = StIdle;
            end else begin
               tmr_d = tmr_q + TmrW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy         = (state_q != StIdle);
      mc_cmd_valid = (state_q == StIssue);
      mc_cmd       = cmd_q;
      mc_addr      = addr_q;
      mc_burst_cnt = burst_q;
      r0_ack       = (state_q == StIssue) && mc_cmd_rdy && !owner_q;
      r1_ack       = (state_q == StIssue) && mc_cmd_rdy && owner_q;
      r0_wrdy      = (state_q == StWdata) && mc_datain_rdy && !owner_q;
      r1_wrdy      = (state_q == StWdata) && mc_datain_rdy && owner_q;
      r0_rvalid    = (state_q == StRdata) && mc_read_data_valid && !owner_q;
      r1_rvalid    = (state_q == StRdata) && mc_read_data_valid && owner_q;
      mc_write_data = '0;
      mc_data_mask  = '0;
      if (state_q == StWdata) begin
         mc_write_data = owner_q ? r1_wdata : r0_wdata;
         mc_data_mask  = owner_q ? r1_wmask : r0_wmask;
      end
      rdata       = mc_read_data;
      timeout_err = terr_q;
   end

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Randomized bench for ddr3_cmd_arbiter: a reactive controller model drives each transaction
// and a round-robin/beat-count reference model predicts owner and traffic.
module tb_ddr3_cmd_arbiter;

   localparam int unsigned BPB   = 2;
   localparam int unsigned RDTO  = 1023;
   localparam int          BOUND = 3000;

   logic        clk = 1'b0;
   logic        rst, init_done;
   logic        r0_req, r1_req, r0_ack, r1_ack, r0_wrdy, r1_wrdy, r0_rvalid, r1_rvalid;
   logic [3:0]  r0_cmd, r1_cmd, mc_cmd;
   logic [25:0] r0_addr, r1_addr, mc_addr;
   logic [4:0]  r0_burst, r1_burst, mc_burst_cnt;
   logic [63:0] r0_wdata, r1_wdata, rdata, mc_read_data, mc_write_data;
   logic [7:0]  r0_wmask, r1_wmask, mc_data_mask;
   logic        mc_cmd_rdy, mc_datain_rdy, mc_read_data_valid, mc_cmd_valid, busy, timeout_err;

   int n_checks, n_fail;
   bit model_last;

   typedef struct {
      int ack0, ack1, vcyc, wr0, wr1, rv0, rv1, data_err, unstable, done, last_beat, end_cyc;
      logic [3:0]  cmd;
      logic [25:0] addr;
      logic [4:0]  burst;
   } obs_t;

   always #5 clk = ~clk;

   ddr3_cmd_arbiter #(.BEATS_PER_BURST(BPB), .RD_TIMEOUT(RDTO)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .r0_req(r0_req), .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_burst(r0_burst),
      .r0_ack(r0_ack), .r0_wdata(r0_wdata), .r0_wmask(r0_wmask), .r0_wrdy(r0_wrdy),
      .r0_rvalid(r0_rvalid),
      .r1_req(r1_req), .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_burst(r1_burst),
      .r1_ack(r1_ack), .r1_wdata(r1_wdata), .r1_wmask(r1_wmask), .r1_wrdy(r1_wrdy),
      .r1_rvalid(r1_rvalid),
      .rdata(rdata), .mc_cmd_rdy(mc_cmd_rdy), .mc_datain_rdy(mc_datain_rdy),
      .mc_read_data_valid(mc_read_data_valid), .mc_read_data(mc_read_data),
      .mc_cmd_valid(mc_cmd_valid), .mc_cmd(mc_cmd), .mc_addr(mc_addr),
      .mc_burst_cnt(mc_burst_cnt), .mc_write_data(mc_write_data), .mc_data_mask(mc_data_mask),
      .busy(busy), .timeout_err(timeout_err)
   );

   // Reference: READ/READA carry read data, WRITE/WRITEA write data, anything else none.
   function automatic bit ref_is_read(input logic [3:0] c);
      return (c == 4'b0001) || (c == 4'b0011);
   endfunction
   function automatic bit ref_is_write(input logic [3:0] c);
      return (c == 4'b0010) || (c == 4'b0100);
   endfunction
   function automatic int ref_beats(input logic [4:0] b);
      int units;
      units = (b == 5'd0) ? 32 : int'(b);
      return units * int'(BPB);
   endfunction
   function automatic int ref_owner(input bit p0, input bit p1);
      if (p0 && p1) return model_last ? 0 : 1;
      return p0 ? 0 : 1;
   endfunction

   task automatic set_req(input int who, input logic [3:0] c, input logic [25:0] a,
                          input logic [4:0] b);
      if (who == 0) begin
         r0_cmd = c; r0_addr = a; r0_burst = b; r0_req = 1'b1;
      end else begin
         r1_cmd = c; r1_addr = a; r1_burst = b; r1_req = 1'b1;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1; init_done = 1'b1; r0_req = 1'b0; r1_req = 1'b0;
      mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0; mc_read_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      model_last = 1'b1;
   endtask

   // Controller model: accepts the command after cmd_delay valid cycles, then offers data
   // beats (reads capped at give_beats) with gap_pct percent idle cycles, until busy drops.
   task automatic serve(input int cmd_delay, input int give_beats, input int gap_pct,
                        input bit drop_init, output obs_t o);
      bit accepted, drop0, drop1;
      int given;
      o = '{default: 0};
      accepted = 0; drop0 = 0; drop1 = 0; given = 0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < BOUND; cyc++) begin
         if (drop0) begin r0_req = 1'b0; drop0 = 0; end
         if (drop1) begin r1_req = 1'b0; drop1 = 0; end
         r0_wdata = {$urandom, $urandom}; r0_wmask = 8'($urandom);
         r1_wdata = {$urandom, $urandom}; r1_wmask = 8'($urandom);
         mc_read_data = {$urandom, $urandom};
         mc_cmd_rdy = mc_cmd_valid && (o.vcyc >= cmd_delay);
         mc_datain_rdy = 1'b0;
         mc_read_data_valid = 1'b0;
         if (accepted && busy && ref_is_write(o.cmd))
            mc_datain_rdy = ($urandom_range(99) >= gap_pct);
         if (accepted && busy && ref_is_read(o.cmd) && given < give_beats) begin
            mc_read_data_valid = ($urandom_range(99) >= gap_pct);
            if (mc_read_data_valid) begin given++; o.last_beat = cyc; end
         end
         @(negedge clk);
         if (mc_cmd_valid) begin
            if (o.vcyc == 0) begin
               o.cmd = mc_cmd; o.addr = mc_addr; o.burst = mc_burst_cnt;
            end else if (mc_cmd !== o.cmd || mc_addr !== o.addr || mc_burst_cnt !== o.burst) begin
               o.unstable++;
            end
            o.vcyc++;
         end
         o.ack0 += int'(r0_ack); o.ack1 += int'(r1_ack);
         o.wr0  += int'(r0_wrdy); o.wr1 += int'(r1_wrdy);
         o.rv0  += int'(r0_rvalid); o.rv1 += int'(r1_rvalid);
         if (r0_ack) drop0 = 1;
         if (r1_ack) drop1 = 1;
         if (r0_ack || r1_ack) begin
            accepted = 1;
            if (drop_init) init_done = 1'b0;
         end
         if (r0_wrdy && (mc_write_data !== r0_wdata || mc_data_mask !== r0_wmask)) o.data_err++;
         if (r1_wrdy && (mc_write_data !== r1_wdata || mc_data_mask !== r1_wmask)) o.data_err++;
         if ((r0_rvalid || r1_rvalid) && rdata !== mc_read_data) o.data_err++;
         if (accepted && !busy) begin
            o.done = 1; o.end_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0; mc_read_data_valid = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      mc_read_data_valid = 1'b1; mc_datain_rdy = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, mc_cmd_valid, r0_ack, r1_ack, r0_wrdy, r1_wrdy, r0_rvalid, r1_rvalid,
           timeout_err} !== 9'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {busy, mc_cmd_valid, r0_ack,
            r1_ack, r0_wrdy, r1_wrdy, r0_rvalid, r1_rvalid, timeout_err});
      end
      n_checks++;
      if ({mc_cmd, mc_addr, mc_burst_cnt} !== 35'd0) begin
         n_fail++; $display("FAIL reset_fields: got %h expected 0", {mc_cmd, mc_addr, mc_burst_cnt});
      end
      mc_read_data_valid = 1'b0; mc_datain_rdy = 1'b0;
   endtask

   task automatic test_write_basic();
      obs_t o;
      set_req(0, 4'b0010, 26'h100, 5'd1);
      serve(2, 0, 0, 0, o);
      model_last = 0;
      n_checks++; if (o.done !== 1) begin n_fail++; $display("FAIL wr_done: got %0d expected 1", o.done); end
      n_checks++; if (o.vcyc !== 3) begin n_fail++; $display("FAIL wr_valid_cycles: got %0d expected 3", o.vcyc); end
      n_checks++; if (o.ack0 !== 1 || o.ack1 !== 0) begin n_fail++; $display("FAIL wr_ack: got %0d/%0d expected 1/0", o.ack0, o.ack1); end
      n_checks++; if (o.wr0 !== 2 || o.wr1 !== 0) begin n_fail++; $display("FAIL wr_beats: got %0d/%0d expected 2/0", o.wr0, o.wr1); end
      n_checks++; if (o.cmd !== 4'b0010 || o.addr !== 26'h100 || o.burst !== 5'd1) begin n_fail++; $display("FAIL wr_fields: got %h/%h/%0d expected 2/100/1", o.cmd, o.addr, o.burst); end
      n_checks++; if (o.unstable !== 0 || o.data_err !== 0) begin n_fail++; $display("FAIL wr_stable_data: got %0d/%0d expected 0/0", o.unstable, o.data_err); end
   endtask

   task automatic test_burst0();
      obs_t o;
      set_req(1, 4'b0001, 26'h2000, 5'd0);
      set_req(0, 4'b0011, 26'h3000, 5'd1);
      serve(1, 1000, 30, 0, o);
      n_checks++; if (o.ack1 !== 1 || o.ack0 !== 0) begin n_fail++; $display("FAIL b0_ack: got %0d/%0d expected 0/1", o.ack0, o.ack1); end
      n_checks++; if (o.rv1 !== 64 || o.rv0 !== 0) begin n_fail++; $display("FAIL b0_beats: got %0d/%0d expected 0/64", o.rv0, o.rv1); end
      n_checks++; if (o.data_err !== 0) begin n_fail++; $display("FAIL b0_rdata: got %0d expected 0", o.data_err); end
      serve(0, 1000, 0, 0, o);
      model_last = 0;
      n_checks++; if (o.ack0 !== 1 || o.rv0 !== 2 || o.rv1 !== 0) begin n_fail++; $display("FAIL b0_next: got ack0=%0d rv0=%0d rv1=%0d expected 1/2/0", o.ack0, o.rv0, o.rv1); end
   endtask

   task automatic test_tie();
      obs_t o;
      apply_reset();
      set_req(0, 4'b0001, 26'h40, 5'd1);
      set_req(1, 4'b0001, 26'h80, 5'd1);
      serve(0, 1000, 20, 0, o);
      n_checks++; if (o.ack0 !== 1 || o.ack1 !== 0 || o.rv0 !== 2 || o.rv1 !== 0) begin n_fail++; $display("FAIL tie_first: got ack %0d/%0d rv %0d/%0d expected 1/0 2/0", o.ack0, o.ack1, o.rv0, o.rv1); end
      serve(0, 1000, 20, 0, o);
      model_last = 1;
      n_checks++; if (o.ack1 !== 1 || o.ack0 !== 0 || o.rv1 !== 2 || o.rv0 !== 0) begin n_fail++; $display("FAIL tie_second: got ack %0d/%0d rv %0d/%0d expected 0/1 0/2", o.ack0, o.ack1, o.rv0, o.rv1); end
      n_checks++; if (o.addr !== 26'h80) begin n_fail++; $display("FAIL tie_addr: got %h expected 80", o.addr); end
   endtask

   task automatic test_timeout();
      obs_t o;
      int gap;
      set_req(0, 4'b0001, 26'h500, 5'd2);
      serve(0, 3, 0, 0, o);
      model_last = 0;
      gap = o.end_cyc - o.last_beat;
      n_checks++; if (o.done !== 1 || o.rv0 !== 3) begin n_fail++; $display("FAIL to_beats: got done=%0d rv0=%0d expected 1/3", o.done, o.rv0); end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", timeout_err); end
      n_checks++; if (gap < int'(RDTO) || gap > int'(RDTO) + 2) begin n_fail++; $display("FAIL to_gap: got %0d expected about %0d", gap, RDTO + 1); end
      @(posedge clk); #1 mc_read_data_valid = 1'b1;
      @(negedge clk);
      n_checks++; if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin n_fail++; $display("FAIL to_stray: got %b expected 000", {r0_rvalid, r1_rvalid, busy}); end
      mc_read_data_valid = 1'b0;
      set_req(1, 4'b0100, 26'h600, 5'd1);
      serve(0, 0, 25, 0, o);
      model_last = 1;
      n_checks++; if (o.wr1 !== 2 || o.wr0 !== 0 || o.data_err !== 0) begin n_fail++; $display("FAIL to_after_wr: got wr %0d/%0d err %0d expected 0/2 0", o.wr0, o.wr1, o.data_err); end
      n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
   endtask

   task automatic test_init_done();
      obs_t o;
      int seen;
      init_done = 1'b0;
      set_req(0, 4'b0100, 26'h700, 5'd1);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         seen += int'(mc_cmd_valid) + int'(busy);
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL init_gate: got %0d active cycles expected 0", seen); end
      @(posedge clk); #1 init_done = 1'b1;
      @(negedge clk);
      n_checks++; if (mc_cmd_valid !== 1'b0) begin n_fail++; $display("FAIL init_rise_same: got %b expected 0", mc_cmd_valid); end
      @(negedge clk);
      n_checks++; if (mc_cmd_valid !== 1'b1) begin n_fail++; $display("FAIL init_rise_next: got %b expected 1", mc_cmd_valid); end
      set_req(1, 4'b0001, 26'h710, 5'd1);
      serve(0, 0, 20, 1, o);
      model_last = 0;
      n_checks++; if (o.done !== 1 || o.ack0 !== 1 || o.wr0 !== 2 || o.ack1 !== 0) begin n_fail++; $display("FAIL init_drop_complete: got done=%0d ack0=%0d wr0=%0d ack1=%0d expected 1/1/2/0", o.done, o.ack0, o.wr0, o.ack1); end
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         seen += int'(busy) + int'(r1_ack);
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL init_low_no_grant: got %0d expected 0", seen); end
      init_done = 1'b1;
      serve(0, 1000, 0, 0, o);
      model_last = 1;
      n_checks++; if (o.ack1 !== 1 || o.rv1 !== 2) begin n_fail++; $display("FAIL init_regrant: got ack1=%0d rv1=%0d expected 1/2", o.ack1, o.rv1); end
   endtask

   task automatic test_reset_mid_write();
      int beats;
      beats = 0;
      set_req(0, 4'b0010, 26'h900, 5'd3);
      for (int i = 0; i < 20 && beats < 2; i++) begin
         @(posedge clk); #1;
         r0_wdata = {$urandom, $urandom}; r0_wmask = 8'hff;
         mc_cmd_rdy = mc_cmd_valid; mc_datain_rdy = 1'b1;
         @(negedge clk);
         if (r0_ack) r0_req = 1'b0;
         beats += int'(r0_wrdy);
      end
      n_checks++; if (beats !== 2 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach: got beats=%0d busy=%b expected 2/1", beats, busy); end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, mc_cmd_valid, r0_ack, r1_ack, r0_wrdy, r1_wrdy, r0_rvalid, r1_rvalid,
           timeout_err} !== 9'd0) begin
         n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0", {busy, mc_cmd_valid, r0_ack,
            r1_ack, r0_wrdy, r1_wrdy, r0_rvalid, r1_rvalid, timeout_err});
      end
      n_checks++;
      if ({mc_cmd, mc_addr, mc_burst_cnt, mc_write_data, mc_data_mask} !== 107'd0) begin
         n_fail++; $display("FAIL rstmid_fields: got %h expected 0", {mc_cmd, mc_addr, mc_burst_cnt, mc_write_data, mc_data_mask});
      end
      r0_req = 1'b0; mc_cmd_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mc_read_data_valid = 1'b1;
      model_last = 1;
      beats = 0;
      repeat (3) begin
         @(negedge clk);
         beats += int'(r0_wrdy) + int'(r1_wrdy) + int'(r0_rvalid) + int'(r1_rvalid) + int'(busy);
      end
      n_checks++; if (beats !== 0) begin n_fail++; $display("FAIL rstmid_orphans: got %0d expected 0", beats); end
      mc_read_data_valid = 1'b0; mc_datain_rdy = 1'b0;
   endtask

   task automatic test_random();
      obs_t o;
      logic [3:0]  cmd_tab [7];
      bit          pend [2];
      logic [3:0]  pc [2];
      logic [25:0] pa [2];
      logic [4:0]  pb [2];
      int own, oth, exp_rd, exp_wr, got_ack[2], got_rv[2], got_wr[2];
      cmd_tab = '{4'h1, 4'h3, 4'h2, 4'h4, 4'h0, 4'h8, 4'hf};
      pend = '{0, 0};
      for (int t = 0; t < 25; t++) begin
         for (int w = 0; w < 2; w++) begin
            if (!pend[w] && ($urandom_range(99) < 60 || (w == 1 && !pend[0]))) begin
               pend[w] = 1;
               pc[w] = cmd_tab[$urandom_range(6)];
               pa[w] = 26'($urandom);
               pb[w] = 5'($urandom_range(4));
               set_req(w, pc[w], pa[w], pb[w]);
            end
         end
         own = ref_owner(pend[0], pend[1]);
         oth = 1 - own;
         exp_rd = ref_is_read(pc[own]) ? ref_beats(pb[own]) : 0;
         exp_wr = ref_is_write(pc[own]) ? ref_beats(pb[own]) : 0;
         serve($urandom_range(3), 1000, $urandom_range(60), 0, o);
         model_last = (own == 1);
         pend[own] = 0;
         got_ack = '{o.ack0, o.ack1}; got_rv = '{o.rv0, o.rv1}; got_wr = '{o.wr0, o.wr1};
         n_checks++; if (o.done !== 1 || got_ack[own] !== 1 || got_ack[oth] !== 0) begin n_fail++; $display("FAIL rnd_owner t%0d: got done=%0d ack0=%0d ack1=%0d expected owner %0d", t, o.done, o.ack0, o.ack1, own); end
         n_checks++; if (o.cmd !== pc[own] || o.addr !== pa[own] || o.burst !== pb[own]) begin n_fail++; $display("FAIL rnd_fields t%0d: got %h/%h/%0d expected %h/%h/%0d", t, o.cmd, o.addr, o.burst, pc[own], pa[own], pb[own]); end
         n_checks++; if (got_rv[own] !== exp_rd || got_wr[own] !== exp_wr || got_rv[oth] !== 0 || got_wr[oth] !== 0) begin n_fail++; $display("FAIL rnd_beats t%0d: got rv=%0d/%0d wr=%0d/%0d expected owner rd=%0d wr=%0d", t, o.rv0, o.rv1, o.wr0, o.wr1, exp_rd, exp_wr); end
         n_checks++; if (o.data_err !== 0 || o.unstable !== 0) begin n_fail++; $display("FAIL rnd_data t%0d: got err=%0d unstable=%0d expected 0/0", t, o.data_err, o.unstable); end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; init_done = 1'b1;
      r0_req = 1'b0; r0_cmd = '0; r0_addr = '0; r0_burst = '0; r0_wdata = '0; r0_wmask = '0;
      r1_req = 1'b0; r1_cmd = '0; r1_addr = '0; r1_burst = '0; r1_wdata = '0; r1_wmask = '0;
      mc_cmd_rdy = 1'b0; mc_datain_rdy = 1'b0; mc_read_data_valid = 1'b0; mc_read_data = '0;
      test_reset();
      test_write_basic();
      test_burst0();
      test_tie();
      test_timeout();
      test_init_done();
      test_reset_mid_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ddr3_cmd_arbiter.md
DDR3_CMD_ARBITER -- requirements
Module: ddr3_cmd_arbiter

Interface
REQ-001 SHALL have parameter BEATS_PER_BURST, default 2: 64-bit local-bus beats per burst-count unit.
REQ-002 SHALL have parameter RD_TIMEOUT, default 1023: max cycles between read beats before abort.
REQ-003 SHALL have clock clk; reset rst, asynchronous, active-high.
REQ-004 SHALL have ports, per line name  direction  width  meaning:
- clk  in  1  DDR3 controller sclk
- rst  in  1  async active-high reset
- init_done  in  1  controller init complete; gates new grants
- rN_req  in  1  requester N (N=0,1) command request, held until rN_ack
- rN_cmd  in  4  0001 READ, 0011 READA, 0010 WRITE, 0100 WRITEA
- rN_addr  in  26  local address
- rN_burst  in  5  burst count; 0 means 32
- rN_ack  out  1  one-cycle pulse: command accepted by controller
- rN_wdata / rN_wmask  in  64 / 8  write beat and mask
- rN_wrdy  out  1  write beat consumed this cycle
- rN_rvalid  out  1  mc_read_data beat belongs to N
- rdata  out  64  mc_read_data passthrough
- mc_cmd_rdy, mc_datain_rdy, mc_read_data_valid  in  1  controller handshakes
- mc_read_data  in  64  controller read data
- mc_cmd_valid  out  1; mc_cmd  out  4; mc_addr  out  26; mc_burst_cnt  out  5  controller command
- mc_write_data / mc_data_mask  out  64 / 8  owner's write beat
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky read-timeout flag

Function
REQ-005 SHALL implement FSM IDLE, ISSUE, WDATA, RDATA; one transaction in flight.
REQ-006 IDLE: if init_done and any rN_req, grant, latch owner/cmd/addr/burst into registers, go ISSUE next cycle.
REQ-007 Both requesting: grant the one not granted last; last-grant register resets to 1 (r0 wins first tie).
REQ-008 ISSUE: mc_cmd_valid=1 with latched fields, held stable until mc_cmd_rdy; in that cycle pulse owner's rN_ack.
REQ-009 After accept: READ/READA -> RDATA; WRITE/WRITEA -> WDATA; any other code -> IDLE with no data phase.
REQ-010 Beat count = (burst==0 ? 32 : burst) * BEATS_PER_BURST, loaded into down-counter at accept.
REQ-011 WDATA: mc_write_data/mc_data_mask combinationally muxed from owner; owner rN_wrdy = mc_datain_rdy; decrement per mc_datain_rdy; last beat -> IDLE.
REQ-012 RDATA: owner rN_rvalid = mc_read_data_valid; decrement per beat; last beat -> IDLE.
REQ-013 RDATA: timer resets on each beat; reaching RD_TIMEOUT with no beat sets timeout_err, -> IDLE.
REQ-014 mc_read_data_valid outside RDATA SHALL be ignored (no rN_rvalid).
REQ-015 Non-owner rN_wrdy/rN_rvalid/rN_ack SHALL stay 0.
REQ-016 init_done deasserting mid-transaction: current transaction completes; no new grant until reasserted.
REQ-017 Re-grant from IDLE earliest the cycle after returning to IDLE (one idle cycle between transactions).

Reset
REQ-018 On rst: state IDLE; mc_cmd_valid, rN_ack, rN_wrdy, rN_rvalid, busy, timeout_err 0; mc_cmd/addr/burst 0; counters 0; last-grant 1.
REQ-019 rst mid-transaction aborts immediately; outstanding controller beats after release are ignored per REQ-014.
REQ-020 timeout_err clears only on rst.

Structure
REQ-021 Command encodings, is_read/is_write helpers, widths (26/64/8/5) SHALL live in shared package ddr3_pkg, also used by ddr3_data_exercise_sm.
REQ-022 Round-robin grant logic SHALL be sub-module rr_arb2 (req[1:0], last -> grant[1:0]); rest flat.

Verification
REQ-023 r0 WRITE addr 0x100 burst 1, mc_cmd_rdy after 3 cycles -> mc_cmd_valid held 3 cycles, r0_ack one pulse, exactly 2 r0_wrdy beats, then IDLE.
REQ-024 r0 and r1 request same cycle after reset, both READ burst 1 -> r0 served first, then r1; r1_rvalid only on r1's 2 beats.
REQ-025 r1 READ burst 0 -> 64 beats routed to r1 before next grant; r0 request held throughout receives ack afterwards.
REQ-026 READ burst 2, controller returns 3 beats then stalls RD_TIMEOUT cycles -> timeout_err=1, IDLE, stray 4th beat ignored.
REQ-027 init_done=0 with r0_req high -> no mc_cmd_valid; init_done rises -> grant next cycle; rst asserted in WDATA -> all outputs 0 same cycle.
